uart_tx_arbiter: RTL

//  Shares the single UART TX write port (wr_en/wr_data, tx_full/tx_half_full) among N byte

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter: state encoding, byte width and a
// constant-width helper.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Ceiling log2, never below 1 so every counter keeps at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating priority encoder: first requester at or above rr_ptr (wrapping)
// wins; returns one-hot winner, its index and an any-request flag.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic [PTR_W-1:0] winner_idx,
  output logic             any
);

  logic [PTR_W-1:0] idx;

  // NOTE: every output gets a default before the loop, so no path leaves a latch.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    idx        = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[idx]) begin
        any         = 1'b1;
        winner_idx  = idx;
        winner[idx] = 1'b1;
      end
      idx = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-aware round-robin arbiter sharing one UART TX write port among
// N_REQ byte streams, with burst limit and stall revocation.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int MAX_BURST   = 16,
  parameter int STALL_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    tx_full,
  input  logic                    tx_half_full,
  output logic                    uart_wr_en,
  output logic [BYTE_W-1:0]       uart_wr_data,
  output logic [N_REQ-1:0]        grant,
  output logic                    abort
);

  localparam int PTR_W   = clog2(N_REQ);
  localparam int BEAT_W  = clog2(MAX_BURST + 1);
  localparam int STALL_W = clog2(STALL_LIMIT + 1);

  arb_state_e       state;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] rr_ptr;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [STALL_W-1:0] stall_cnt;

  logic [N_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;

  logic              sel_valid;
  logic              sel_last;
  logic [BYTE_W-1:0] sel_data;
  logic              blk;
  logic              beat;
  logic [PTR_W-1:0]  next_ptr;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req        (req_valid),
    .rr_ptr     (rr_ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == PTR_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Half-full only throttles the low-priority streams; requester 0 runs until full.
  assign blk       = tx_full | (tx_half_full & (owner != '0));
  assign req_ready = (state == ST_OWN && !blk) ? grant : '0;
  assign beat      = (state == ST_OWN) & sel_valid & ~blk;
  assign next_ptr  = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      grant        <= '0;
      owner        <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      stall_cnt    <= '0;
      uart_wr_en   <= 1'b0;
      uart_wr_data <= '0;
      abort        <= 1'b0;
    end else begin
      uart_wr_en <= 1'b0;
      abort      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state     <= ST_OWN;
            grant     <= pick_onehot;
            owner     <= pick_idx;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        ST_OWN: begin
          if (beat) begin
            uart_wr_en   <= 1'b1;
            uart_wr_data <= sel_data;
            stall_cnt    <= '0;
            if (sel_last || beat_cnt == BEAT_W'(MAX_BURST - 1)) begin
              state    <= ST_IDLE;
              grant    <= '0;
              beat_cnt <= '0;
              rr_ptr   <= next_ptr;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end else if (!sel_valid && !blk) begin
            // Owner idle with room in the FIFO: this is a genuine stall.
            if (stall_cnt == STALL_W'(STALL_LIMIT - 1)) begin
              state     <= ST_IDLE;
              grant     <= '0;
              beat_cnt  <= '0;
              stall_cnt <= '0;
              rr_ptr    <= next_ptr;
              abort     <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + STALL_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
